// File: rtl/sm_seg_scanner_if.sv
// Display-side bundle of the 4-digit 7-segment scanner: scan enable, data and
// decimal points in; pin image, digit index, frame pulse and phase debug out.
interface sm_seg_scanner_if;
  logic        en;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [15:0] gpio_o;
  logic [1:0]  digit_o;
  logic        frame_o;
  logic        state_o;   // 1 = SHOW phase, 0 = BLANK phase

  modport master (
    output en, data_i, dp_i,
    input  gpio_o, digit_o, frame_o, state_o
  );

  modport slave (
    input  en, data_i, dp_i,
    output gpio_o, digit_o, frame_o, state_o
  );
endinterface

// File: rtl/sm_seg_scanner.sv
// Registered 4-digit 7-segment scan driver with a per-slot dead-time blank.
// Optional leading-zero blanking is compiled in with `define SM_SEG_LZB_EN.
module sm_seg_scanner #(
  parameter int PRESCALE  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  sm_seg_scanner_if.slave    bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} phase_t;
  localparam phase_t PHASE_RST = (BLANK_CYC == 0) ? SHOW : BLANK;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  phase_t        phase_q, phase_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    dp_snap_q, dp_snap_d;
  logic [15:0]   gpio_q, gpio_d;
  logic [1:0]    digit_o_q;
  logic          frame_q, frame_d;

  logic          wrap;
  logic [3:0]    nib;
  logic [15:0]   hi_bits;
  logic          lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign wrap = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    cnt_d     = cnt_q;
    digit_d   = digit_q;
    phase_d   = phase_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    frame_d   = 1'b0;
    gpio_d    = 16'h00FF;
    nib       = 4'h0;
    hi_bits   = 16'h0;
    lz_blank  = 1'b0;

    if (bus.en) begin
      if (wrap) begin
        cnt_d   = '0;
        digit_d = digit_q + 2'd1;
        if (BLANK_CYC > 0) phase_d = BLANK;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (int'(cnt_d) == BLANK_CYC) phase_d = SHOW;

      // Snapshot at the top of the frame; the decode below already sees it.
      if (cnt_q == '0 && digit_q == 2'd0) begin
        snap_d    = bus.data_i;
        dp_snap_d = bus.dp_i;
        frame_d   = 1'b1;
      end
    end

    nib     = snap_d[{digit_q, 2'b00} +: 4];
    hi_bits = snap_d >> {digit_q, 2'b00};
`ifdef SM_SEG_LZB_EN
    lz_blank = (digit_q != 2'd0) && (hi_bits == 16'h0) && !dp_snap_d[digit_q];
`else
    lz_blank = 1'b0;
`endif

    if (bus.en && phase_q == SHOW && !lz_blank)
      gpio_d = {4'b0000, 4'b0001 << digit_q, ~hex7(nib), ~dp_snap_d[digit_q]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      digit_q   <= 2'd0;
      phase_q   <= PHASE_RST;
      snap_q    <= 16'h0;
      dp_snap_q <= 4'h0;
      gpio_q    <= 16'h00FF;
      digit_o_q <= 2'd0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      phase_q   <= phase_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      gpio_q    <= gpio_d;
      digit_o_q <= digit_q;
      frame_q   <= frame_d;
    end
  end

  assign bus.gpio_o  = gpio_q;
  assign bus.digit_o = digit_o_q;
  assign bus.frame_o = frame_q;
  assign bus.state_o = (phase_q == SHOW);
endmodule

// File: tb/tb_sm_seg_scanner.sv
// Scoreboard bench for sm_seg_scanner: a frame-position model predicts every
// output cycle, a negedge monitor pops and compares.
module tb_sm_seg_scanner;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * PS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm_seg_scanner_if bus ();

  sm_seg_scanner #(.PRESCALE(PS), .BLANK_CYC(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [18:0] exp_q[$];   // {frame, digit, gpio}
  int checks = 0;
  int errors = 0;

  int          pos = 0;    // position within the 32-cycle frame
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [15:0] show_val(int k);
    logic [3:0] anode;
    logic [3:0] n;
    anode = 4'b0001 << k;
    n     = 4'((m_snap >> (4 * k)) & 16'hF);
    return {4'b0000, anode, ~hex_tab[n], ~m_dp[k]};
  endfunction

  function automatic bit lz_blank(int k);
`ifdef SM_SEG_LZB_EN
    return (k > 0) && ((m_snap >> (4 * k)) == 16'h0) && !m_dp[k];
`else
    return (k < 0);
`endif
  endfunction

  // Reference model: evaluates the cycle at each rising edge.
  always @(posedge clk) begin
    logic [15:0] g;
    logic        fr;
    if (rst) begin
      pos = 0;
      m_snap = 16'h0;
      m_dp = 4'h0;
      exp_q.delete();
    end else begin
      g  = 16'h00FF;
      fr = 1'b0;
      if (bus.en) begin
        if (pos == 0) begin
          m_snap = bus.data_i;
          m_dp   = bus.dp_i;
          fr     = 1'b1;
        end
        if ((pos % PS) >= BC && !lz_blank(pos / PS)) g = show_val(pos / PS);
      end
      exp_q.push_back({fr, 2'(pos / PS), g});
      if (bus.en) pos = (pos + 1) % FRAME;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty: no expected entry at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({bus.frame_o, bus.digit_o, bus.gpio_o} !== e)
        begin
          errors++;
          $display("FAIL out t=%0t: got frame=%0b digit=%0d gpio=%h, exp frame=%0b digit=%0d gpio=%h",
                   $time, bus.frame_o, bus.digit_o, bus.gpio_o, e[18], e[17:16], e[15:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (bus.gpio_o !== 16'h00FF || bus.digit_o !== 2'd0 || bus.frame_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got gpio=%h digit=%0d frame=%0b, exp gpio=00ff digit=0 frame=0",
               name, bus.gpio_o, bus.digit_o, bus.frame_o);
    end
  endtask

  initial begin
    bus.en     = 1'b0;
    bus.data_i = 16'h0;
    bus.dp_i   = 4'h0;
    rst        = 1'b1;
    step(3);
    check_reset("reset_init");

    rst        = 1'b0;
    bus.en     = 1'b1;
    bus.data_i = 16'h1234;
    step(70);

    bus.data_i = 16'hFFFF;         // mid-frame change, visible next frame
    step(60);

    bus.data_i = 16'h0007;
    bus.dp_i   = 4'h0;
    step(70);

    bus.dp_i   = 4'b0100;
    step(40);

    for (int i = 0; i < 40; i++) begin
      bus.data_i = ($urandom_range(0, 2) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      bus.dp_i   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      bus.en     = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 20));
    end

    // Asynchronous reset at cnt=4 of digit1.
    bus.en = 1'b1;
    for (int i = 0; i < 2 * FRAME && pos != PS + 4; i++) @(negedge clk);
    checks++;
    if (pos != PS + 4) begin
      errors++;
      $display("FAIL reach_pos: got pos=%0d, exp %0d", pos, PS + 4);
    end
    #2 rst = 1'b1;
    #1 check_reset("reset_async");
    @(negedge clk);
    #1 rst = 1'b0;
    bus.data_i = 16'hA5C3;
    bus.dp_i   = 4'b1001;
    step(80);

    bus.en = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
